ring_osc_freq_meter: RTL and testbench
======================================

# ring_osc_freq_meter

Parametrised, gateable ring oscillator with an on-chip frequency counter. Runs an odd-inversion ring (or an external test clock), prescales it in its own domain, synchronises it into `clk`, and counts prescaled rising edges over a fixed gate window. Sits behind the top-level switch/pin wrapper and is the successor to the fixed three-stage gated ring: adds stage-count parameterisation, source select, measurement and a result handshake.

## Interface
- `STAGES`, 5: total ring inversions; odd and ≥3. One NAND enable gate plus `STAGES-1` inverters.
- `PRESCALE`, 3: ring-domain ripple divider depth; divides by 2^PRESCALE.
- `WIN_LOG2`, 10: gate window length, 2^WIN_LOG2 `clk` cycles.
- `CNT_W`, 16: result width.

- `clk` in 1: system clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `osc_en` in 1: ring enable; ring held static when low or while `rst_n` is low.
- `src_sel` in 1: 0 = internal ring, 1 = `ext_osc`.
- `ext_osc` in 1: external test oscillator.
- `start` in 1: single-cycle request to begin a measurement.
- `cont` in 1: continuous-mode request; used only when `FREQ_METER_CONT_EN` is defined.
- `ring_tap` out 1: raw ring output, for pad observation.
- `busy` out 1: measurement in progress.
- `valid` out 1: `count` holds a completed result.
- `count` out CNT_W: prescaled edge count for the last window.
- `saturated` out 1: `count` clipped at all-ones in the last window.

## Operation
- Source mux output drives a `PRESCALE`-bit ripple divider, which is asynchronously cleared by `rst_n`. The MSB passes through a 2-flop synchroniser into `clk`, followed by an edge-detect register.
- FSM states:
  - IDLE: entered on reset.
  - SETTLE: 4 cycles to flush the synchroniser and edge register.
  - MEASURE: exactly 2^WIN_LOG2 cycles.
  - DONE.
- Transitions:
  - IDLE or DONE + `start` → SETTLE.
  - SETTLE → MEASURE after 4 cycles.
  - MEASURE → DONE after the window ends.
  - `start` is ignored in SETTLE and MEASURE.
- Accumulator:
  - Cleared on entry to MEASURE.
  - Increments on each synchronised rising edge.
  - Sticks at 2^CNT_W−1 and sets the internal saturation flag. No wrap.
- Result latch: on MEASURE→DONE, `count` and `saturated` load from the accumulator and `valid` goes to 1.
- `valid` clears on the cycle `start` is accepted. `count` keeps its previous value until the next latch.
- Changes to `osc_en` or `src_sel` mid-window are not blocked. The window completes and counts whatever edges arrive.
- Frequency constraint: the prescaled rate must be below `clk`/4, otherwise the count is undefined (not checked).
- Reset value of all outputs is 0: `busy`, `valid`, `count`, `saturated`, and `ring_tap` (ring static). FSM returns to IDLE. `rst_n` low mid-measurement discards the window.

## Timing
- `start` is sampled at edge 0. `busy` is 1 from edge 1.
- MEASURE occupies edges 5 to 4+2^WIN_LOG2.
- `valid` and `count` update at edge 5+2^WIN_LOG2; `busy` falls at the same edge.
- Input-to-count latency of an edge: 2^(PRESCALE−1) source periods plus 3 `clk` cycles. Counts are ±1 edge.
- `start` asserted in the same cycle the FSM enters DONE: ignored. It is accepted only once the FSM is in DONE.

## Configuration
- Macro: `FREQ_METER_CONT_EN`.
- Defined: in DONE with `cont` high, the FSM re-enters MEASURE on the next cycle without SETTLE.
  - `valid` stays 1.
  - `count` and `saturated` refresh every 2^WIN_LOG2+1 cycles.
  - `busy` stays 1 until `cont` is low at a window end.
- Undefined: `cont` is ignored and one-shot operation only.

## Structure
- `ring_meter_pkg` contains:
  - the FSM state enum (IDLE, SETTLE, MEASURE, DONE);
  - `SETTLE_CYCLES = 4`;
  - `SYNC_DEPTH = 2`.
- Sub-module `ring_osc`:
  - `STAGES` parameter;
  - `en` input, `out` output;
  - NAND gate plus inverter chain, with each inverter kept as a named cell instance so synthesis does not collapse the loop.
- The divider, synchroniser, FSM and counter live in the top module.

## Test plan
- Reset → all outputs 0. Drive `start` during reset → still IDLE after release, `valid` stays 0.
- Baseline count: `src_sel`=1, `clk` 10 ns, `ext_osc` 20 ns, defaults, pulse `start`.
  - `busy` rises at edge 1.
  - `valid` rises at edge 1029.
  - `count` is 64±1.
- Saturation: `CNT_W`=4 with the same stimulus → `count`=15, `saturated`=1.
- Ignored start: `start` pulsed mid-MEASURE is ignored.
- Early reset: `rst_n` pulsed low at edge 500 → `busy` and `valid` are 0 immediately. A subsequent `start` yields 64±1.
- Continuous mode: `FREQ_METER_CONT_EN` defined, `cont`=1, `ext_osc` period changed to 40 ns mid-run.
  - Successive results 64±1 → 32±1, one per 1025 cycles.
  - `cont` dropped → `busy` falls at the next window end.

Source files
------------

// File: rtl/ring_meter_pkg.sv
// Shared types and constants for the ring oscillator frequency meter.
package ring_meter_pkg;

    // Measurement sequencer states
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETTLE  = 2'd1,
        MEASURE = 2'd2,
        DONE    = 2'd3
    } meter_state_t;

    // Cycles spent flushing the synchroniser and edge register before a window
    localparam int unsigned SETTLE_CYCLES = 4;
    localparam int unsigned SETTLE_W      = $clog2(SETTLE_CYCLES);

    // Flops in the prescaler-to-clk synchroniser
    localparam int unsigned SYNC_DEPTH    = 2;

endpackage

// File: rtl/ring_inv_cell.sv
// Single ring inverter stage. Kept as its own cell so each stage survives
// synthesis as a separately named instance and the loop is not collapsed.
module ring_inv_cell (
    input  logic a,
    output logic y
);

    // One inversion
    assign y = ~a;

endmodule

// File: rtl/ring_osc.sv
// Gateable ring oscillator: one NAND enable gate followed by STAGES-1
// inverter cells, fed back to the NAND. STAGES must be odd and at least 3.
module ring_osc #(
    parameter int unsigned STAGES = 5
) (
    input  logic en,
    output logic out
);

    // node[0] is the NAND output, node[i] the output of inverter i
    logic [STAGES-1:0] node;

    if (STAGES < 3 || (STAGES % 2) == 0) begin : g_bad_stages
        $error("ring_osc: STAGES must be odd and >= 3");
    end

    // Enable gate closes the loop; with en low the ring parks with node[0] high
    assign node[0] = ~(en & node[STAGES-1]);

    for (genvar i = 1; i < STAGES; i++) begin : g_inv
        ring_inv_cell u_inv (
            .a (node[i-1]),
            .y (node[i])
        );
    end

    // Tap after the first inverter so the parked (disabled) level is 0
    assign out = node[1];

endmodule

// File: rtl/ring_osc_freq_meter.sv
// Ring oscillator with on-chip frequency counter. The selected source is
// ripple-divided by 2^PRESCALE in its own domain, synchronised into clk and
// its rising edges counted over a 2^WIN_LOG2-cycle gate window.
// Optional build macro: FREQ_METER_CONT_EN enables back-to-back windows
// while cont is high.
module ring_osc_freq_meter
    import ring_meter_pkg::*;
#(
    parameter int unsigned STAGES   = 5,
    parameter int unsigned PRESCALE = 3,
    parameter int unsigned WIN_LOG2 = 10,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             osc_en,
    input  logic             src_sel,
    input  logic             ext_osc,
    input  logic             start,
    input  logic             cont,
    output logic             ring_tap,
    output logic             busy,
    output logic             valid,
    output logic [CNT_W-1:0] count,
    output logic             saturated
);

    if (PRESCALE < 1 || WIN_LOG2 < 1 || CNT_W < 1) begin : g_bad_params
        $error("ring_osc_freq_meter: PRESCALE, WIN_LOG2 and CNT_W must be >= 1");
    end

    logic                  ring_en;
    logic                  src_clk;
    logic [PRESCALE-1:0]   div;
    logic [SYNC_DEPTH-1:0] sync_q;
    logic                  edge_q;
    logic                  rise;
    logic                  cont_go;
    logic                  cont_hold;

    meter_state_t          state;
    logic [SETTLE_W-1:0]   settle_cnt;
    logic [WIN_LOG2-1:0]   win_cnt;
    logic [CNT_W-1:0]      acc;
    logic                  sat;
    logic [CNT_W-1:0]      acc_nxt;
    logic                  sat_nxt;

    // Ring is parked whenever disabled or in reset
    assign ring_en = osc_en & rst_n;

    ring_osc #(
        .STAGES (STAGES)
    ) u_ring (
        .en  (ring_en),
        .out (ring_tap)
    );

    // Source select: internal ring or external test clock
    assign src_clk = src_sel ? ext_osc : ring_tap;

    // Ripple divider in the source domain; each stage toggles on the fall of the previous
    for (genvar i = 0; i < PRESCALE; i++) begin : g_div
        logic q;
        if (i == 0) begin : g_first
            // First stage clocked directly by the selected source
            always_ff @(posedge src_clk or negedge rst_n) begin
                if (!rst_n) q <= 1'b0;
                else        q <= ~q;
            end
        end else begin : g_next
            // Later stages clocked by the falling edge of the stage before
            always_ff @(negedge div[i-1] or negedge rst_n) begin
                if (!rst_n) q <= 1'b0;
                else        q <= ~q;
            end
        end
        assign div[i] = q;
    end

    // Bring the prescaled MSB into clk and keep a one-cycle history for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            edge_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_DEPTH-2:0], div[PRESCALE-1]};
            edge_q <= sync_q[SYNC_DEPTH-1];
        end
    end

    assign rise = sync_q[SYNC_DEPTH-1] & ~edge_q;

`ifdef FREQ_METER_CONT_EN
    // Continuous mode: restart straight from DONE and hold busy across windows
    assign cont_go   = (state == DONE) & cont;
    assign cont_hold = cont;
`else
    // One-shot only; cont has no effect
    logic unused_cont;
    assign unused_cont = cont;
    assign cont_go     = 1'b0;
    assign cont_hold   = 1'b0;
`endif

    // Saturating accumulator step for this cycle's edge
    always_comb begin
        acc_nxt = acc;
        sat_nxt = sat;
        if (rise) begin
            if (acc == {CNT_W{1'b1}}) sat_nxt = 1'b1;
            else                      acc_nxt = acc + CNT_W'(1);
        end
    end

    // Measurement sequencer, window counter, accumulator and result latch
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            settle_cnt <= '0;
            win_cnt    <= '0;
            acc        <= '0;
            sat        <= 1'b0;
            busy       <= 1'b0;
            valid      <= 1'b0;
            count      <= '0;
            saturated  <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (cont_go) begin
                        state   <= MEASURE;
                        win_cnt <= '0;
                        acc     <= '0;
                        sat     <= 1'b0;
                        busy    <= 1'b1;
                    end else if (start) begin
                        state      <= SETTLE;
                        settle_cnt <= '0;
                        busy       <= 1'b1;
                        valid      <= 1'b0;
                    end else begin
                        busy <= 1'b0;
                    end
                end
                SETTLE: begin
                    if (settle_cnt == SETTLE_W'(SETTLE_CYCLES - 1)) begin
                        state   <= MEASURE;
                        win_cnt <= '0;
                        acc     <= '0;
                        sat     <= 1'b0;
                    end else begin
                        settle_cnt <= settle_cnt + SETTLE_W'(1);
                    end
                end
                MEASURE: begin
                    if (win_cnt == {WIN_LOG2{1'b1}}) begin
                        state     <= DONE;
                        count     <= acc_nxt;
                        saturated <= sat_nxt;
                        valid     <= 1'b1;
                        busy      <= cont_hold;
                    end else begin
                        win_cnt <= win_cnt + WIN_LOG2'(1);
                    end
                    acc <= acc_nxt;
                    sat <= sat_nxt;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ring_osc_freq_meter.sv
// Directed bench for ring_osc_freq_meter: reset, baseline count, saturation,
// ignored starts, early reset and continuous / one-shot cont handling.
module tb_ring_osc_freq_meter;

    logic        clk;
    logic        rst_n;
    logic        osc_en;
    logic        src_sel;
    logic        ext_osc;
    logic        start;
    logic        cont;

    logic        ring_tap;
    logic        busy;
    logic        valid;
    logic [15:0] count;
    logic        saturated;

    logic        ring_tap_s;
    logic        busy_s;
    logic        valid_s;
    logic [3:0]  count_s;
    logic        saturated_s;

    int          n_total = 0;
    int          n_bad   = 0;
    int          edge_n  = 0;
    int unsigned ext_half = 10;

    ring_osc_freq_meter u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .osc_en    (osc_en),
        .src_sel   (src_sel),
        .ext_osc   (ext_osc),
        .start     (start),
        .cont      (cont),
        .ring_tap  (ring_tap),
        .busy      (busy),
        .valid     (valid),
        .count     (count),
        .saturated (saturated)
    );

    ring_osc_freq_meter #(.CNT_W(4)) u_sat (
        .clk       (clk),
        .rst_n     (rst_n),
        .osc_en    (osc_en),
        .src_sel   (src_sel),
        .ext_osc   (ext_osc),
        .start     (start),
        .cont      (cont),
        .ring_tap  (ring_tap_s),
        .busy      (busy_s),
        .valid     (valid_s),
        .count     (count_s),
        .saturated (saturated_s)
    );

    // 10-unit system clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // External test oscillator; half-period adjustable at run time
    initial begin
        ext_osc = 1'b0;
        forever begin
            #(ext_half);
            ext_osc = ~ext_osc;
        end
    end

    // Hard stop in case something wedges
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, total=%0d", n_total);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Returns the target when got is within one edge of it, else got itself
    function automatic logic [31:0] near(input logic [31:0] got, input logic [31:0] want);
        if (got + 32'd1 >= want && got <= want + 32'd1) return want;
        return got;
    endfunction

    // Advance one clk edge and sample shortly after it
    task automatic tick();
        @(posedge clk);
        #1;
        edge_n++;
    endtask

    task automatic tick_to(input int target);
        while (edge_n < target) tick();
    endtask

    // Raise start after edge 0 so it is taken at edge 1
    task automatic launch();
        edge_n = 0;
        start  = 1'b1;
        tick();
        start  = 1'b0;
    endtask

    task automatic wait_valid(input int limit);
        while (valid !== 1'b1 && edge_n < limit) tick();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        rst_n   = 1'b0;
        osc_en  = 1'b0;
        src_sel = 1'b1;
        start   = 1'b1;
        cont    = 1'b0;

        // Reset with start held high
        repeat (4) tick();
        check("rst_busy",      32'(busy), 0);
        check("rst_valid",     32'(valid), 0);
        check("rst_count",     32'(count), 0);
        check("rst_saturated", 32'(saturated), 0);
        check("rst_ring_tap",  32'(ring_tap), 0);
        rst_n = 1'b1;
        start = 1'b0;
        repeat (6) tick();
        check("idle_after_rst_busy",  32'(busy), 0);
        check("idle_after_rst_valid", 32'(valid), 0);

        // Baseline: 20-unit ext period, /8 prescale -> one edge per 16 cycles -> 64
        launch();
        check("base_busy_e1",  32'(busy), 1);
        check("base_valid_e1", 32'(valid), 0);
        wait_valid(1100);
        check("base_valid_edge", edge_n, 1029);
        check("base_busy_fall",  32'(busy), 0);
        check("base_count",      near(32'(count), 64), 64);
        check("base_saturated",  32'(saturated), 0);
        check("sat_count",       32'(count_s), 15);
        check("sat_flag",        32'(saturated_s), 1);
        check("sat_valid",       32'(valid_s), 1);

        // Restart from DONE, start mid-window ignored, start at DONE entry ignored
        tick();
        launch();
        check("rerun_valid_clear", 32'(valid), 0);
        check("rerun_busy",        32'(busy), 1);
        tick_to(300);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("mid_start_busy", 32'(busy), 1);
        tick_to(1028);
        check("pre_done_valid", 32'(valid), 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("rerun_valid_1029", 32'(valid), 1);
        check("rerun_count",      near(32'(count), 64), 64);
        tick();
        check("done_entry_start_ignored", 32'(busy), 0);
        tick();
        check("done_idle_busy", 32'(busy), 0);

        // Early reset discards the window, next run is normal
        launch();
        tick_to(500);
        check("early_busy_pre", 32'(busy), 1);
        rst_n = 1'b0;
        #1;
        check("early_rst_busy",  32'(busy), 0);
        check("early_rst_valid", 32'(valid), 0);
        check("early_rst_count", 32'(count), 0);
        #1;
        rst_n = 1'b1;
        tick();
        launch();
        wait_valid(1100);
        check("after_rst_valid_edge", edge_n, 1029);
        check("after_rst_count",      near(32'(count), 64), 64);

        // cont handling starts from IDLE
        do_reset();
        cont = 1'b1;
        launch();
        wait_valid(1100);
        check("cont_first_edge",  edge_n, 1029);
        check("cont_first_count", near(32'(count), 64), 64);
`ifdef FREQ_METER_CONT_EN
        check("cont_busy_held", 32'(busy), 1);
        ext_half = 20;
        tick_to(2054);
        check("cont_second_valid", 32'(valid), 1);
        check("cont_second_busy",  32'(busy), 1);
        check("cont_second_count", near(32'(count), 32), 32);
        tick_to(2500);
        cont = 1'b0;
        tick_to(3078);
        check("cont_busy_before_end", 32'(busy), 1);
        tick();
        check("cont_busy_fall",   32'(busy), 0);
        check("cont_third_count", near(32'(count), 32), 32);
        check("cont_valid_kept",  32'(valid), 1);
        tick();
        tick();
        check("cont_stays_done", 32'(busy), 0);
`else
        check("oneshot_busy_fall", 32'(busy), 0);
        tick();
        tick();
        check("oneshot_no_rearm",  32'(busy), 0);
        check("oneshot_valid",     32'(valid), 1);
        cont = 1'b0;
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
